sd_bd_sched: RTL and testbench
==============================

# sd_bd_sched

Buffer-descriptor scheduler for the SD controller. Arbitrates between the TX and RX descriptor queues and fetches each two-word descriptor (system buffer address, then SD block address) through the queue's read port. It launches one block transfer on the data/command engine, waits for completion, error or timeout, then retires the descriptor by signalling completion back to the owning queue.

## Interface
Parameters:
- `ADDR_W`, 32: width of descriptor words and transfer addresses.
- `CNT_W`, 3: width of queue free-count inputs.
- `BD_NUM`, 4: free count of an empty queue; a queue is pending when its free count is not equal to `BD_NUM`.
- `TMO_W`, 16: watchdog width; timeout after 2^TMO_W−1 cycles.

Ports (reset `rst`, asynchronous, active-high; clock `clk`):
- `clk` in 1: clock.
- `rst` in 1: async active-high reset.
- `enable` in 1: allow new descriptors to start.
- `tx_free_bd` in CNT_W: TX queue free count.
- `tx_re` out 1: TX descriptor word read strobe.
- `tx_ack` in 1: TX read data valid.
- `tx_dat` in ADDR_W: TX descriptor word.
- `tx_a_cmp` out 1: TX descriptor retired.
- `rx_free_bd`, `rx_re`, `rx_ack`, `rx_dat`, `rx_a_cmp`: same as the TX ports, for the RX queue.
- `xfer_start` out 1: one-cycle transfer launch.
- `xfer_dir` out 1: 1 = TX (write to card), 0 = RX.
- `xfer_sys_addr` out ADDR_W: system buffer address.
- `xfer_blk_addr` out ADDR_W: SD block address.
- `xfer_done` in 1: transfer finished OK (pulse).
- `xfer_err` in 1: transfer failed (pulse).
- `xfer_abort` out 1: one-cycle abort on watchdog timeout.
- `busy` out 1: state not IDLE.
- `err` out 1: sticky error flag.
- `err_tmo` out 1: sticky flag, last error was a timeout.
- `err_clr` in 1: clears `err` and `err_tmo`.

## Operation
- FSM states: IDLE, RD0, W0, RD1, W1, START, XFER, CMP1, CMP2, SETTLE.
- IDLE: if `enable` and at least one queue is pending, register the grant and go to RD0. Otherwise stay in IDLE.
- Arbitration is round-robin. A `last_tx` flag records which queue was last served. When both queues are pending, the queue not last served wins. At reset, `last_tx` = 0, so TX wins first.
- RD0: assert the granted `*_re` for exactly one cycle, then go to W0.
- W0: wait for the granted `*_ack`, latch `*_dat` into `xfer_sys_addr`, then go to RD1.
- RD1 and W1: same as RD0 and W0, latching into `xfer_blk_addr`. Then go to START.
- START: pulse `xfer_start` and drive `xfer_dir`. Clear the watchdog, then go to XFER.
- XFER: the watchdog increments every cycle.
  - `xfer_err` → set `err`, clear `err_tmo`, go to CMP1.
  - Otherwise `xfer_done` → go to CMP1.
  - Otherwise, when the watchdog reaches all-ones → pulse `xfer_abort`, set `err` and `err_tmo`, go to CMP1.
  - Priority: err > done > timeout.
- W0 and W1 also run the watchdog. On timeout they set `err` and `err_tmo` and go to IDLE without retiring. `last_tx` is not updated.
- CMP1 and CMP2: hold the granted `*_a_cmp` high for exactly 2 cycles. This guarantees the queue sees a rising edge even if its own write-completion update coincides with one cycle. Update `last_tx`.
- SETTLE: one cycle with `*_a_cmp` low so the queue free count updates before re-arbitration. Then go to IDLE.
- A descriptor is always retired (CMP) after START, whether it passed, failed or timed out.
- `enable` is sampled only in IDLE. Deasserting it mid-descriptor does not abort the descriptor.
- `err_clr` clears the flags in any state. A same-cycle set has priority over the clear.
- `busy` = (state != IDLE).
- Reset: state IDLE; all strobes 0; `xfer_dir` 0; both addresses 0; `err` 0; `err_tmo` 0; watchdog 0; `last_tx` 0. Asserting reset mid-transfer drops everything immediately with no `*_a_cmp`.

## Timing
- Cycle 0: IDLE samples pending.
- Cycle 1: `*_re` high.
- Cycle 2: ack, sys addr latched.
- Cycle 3: second `*_re`.
- Cycle 4: ack, blk addr latched.
- Cycle 5: `xfer_start` high, with both addresses and `xfer_dir` already valid and stable until the next START.
- `xfer_done` in cycle N → `*_a_cmp` high N+1..N+2, SETTLE N+3, IDLE N+4. The earliest next `*_re` is N+5.
- `*_re` is never high on two consecutive cycles.
- `tx_*` and `rx_*` strobes are never high simultaneously.

## Configuration
- `SD_BD_SCHED_TX_PRIO_EN` defined: fixed priority. TX always wins when pending, and `last_tx` is ignored.
- `SD_BD_SCHED_TX_PRIO_EN` undefined: round-robin as above.

## Test plan
- TX only, `tx_free_bd`=3, `tx_dat` = 0x1000 then 0x20, `xfer_done` 10 cycles after start → `xfer_start` at cycle 5 with sys=0x1000, blk=0x20, dir=1; `tx_a_cmp` high exactly 2 cycles; `rx_*` idle.
- Both queues pending from reset, two descriptors each → service order TX, RX, TX, RX. With the macro defined: TX, TX, RX, RX.
- `xfer_err` and `xfer_done` in the same cycle → `err`=1, `err_tmo`=0, `a_cmp` pulse still issued. Then `err_clr` → `err`=0.
- `TMO_W`=4, no done → `xfer_abort` 15 cycles after START, `err`=`err_tmo`=1, descriptor retired via `a_cmp`.
- Assert `rst` during XFER → next cycle `busy`=0 and all outputs at reset values, with no `a_cmp`.
- `enable`=0 with queues pending → no `*_re`. Drop `enable` mid-XFER → the current descriptor completes and no new fetch starts.

Source files
------------

// File: rtl/sd_bd_sched_if.sv
// Descriptor-queue, transfer-engine and status signals of sd_bd_sched.
// master = scheduler side, slave = queues/engine/register side.
interface sd_bd_sched_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 3
);
    logic              enable;
    logic [CNT_W-1:0]  tx_free_bd;
    logic              tx_re;
    logic              tx_ack;
    logic [ADDR_W-1:0] tx_dat;
    logic              tx_a_cmp;
    logic [CNT_W-1:0]  rx_free_bd;
    logic              rx_re;
    logic              rx_ack;
    logic [ADDR_W-1:0] rx_dat;
    logic              rx_a_cmp;
    logic              xfer_start;
    logic              xfer_dir;
    logic [ADDR_W-1:0] xfer_sys_addr;
    logic [ADDR_W-1:0] xfer_blk_addr;
    logic              xfer_done;
    logic              xfer_err;
    logic              xfer_abort;
    logic              busy;
    logic              err;
    logic              err_tmo;
    logic              err_clr;

    modport master (
        input  enable, tx_free_bd, tx_ack, tx_dat, rx_free_bd, rx_ack, rx_dat,
               xfer_done, xfer_err, err_clr,
        output tx_re, tx_a_cmp, rx_re, rx_a_cmp, xfer_start, xfer_dir,
               xfer_sys_addr, xfer_blk_addr, xfer_abort, busy, err, err_tmo
    );

    modport slave (
        output enable, tx_free_bd, tx_ack, tx_dat, rx_free_bd, rx_ack, rx_dat,
               xfer_done, xfer_err, err_clr,
        input  tx_re, tx_a_cmp, rx_re, rx_a_cmp, xfer_start, xfer_dir,
               xfer_sys_addr, xfer_blk_addr, xfer_abort, busy, err, err_tmo
    );
endinterface

// File: rtl/sd_bd_sched.sv
// Buffer-descriptor scheduler: fetches TX/RX descriptors, launches one block transfer, retires it.
// Define SD_BD_SCHED_TX_PRIO_EN for fixed TX priority instead of round-robin arbitration.
module sd_bd_sched #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 3,
    parameter int BD_NUM = 4,
    parameter int TMO_W  = 16
) (
    input logic          clk,
    input logic          rst,
    sd_bd_sched_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_W0, S_RD1, S_W1, S_START, S_XFER, S_CMP1, S_CMP2, S_SETTLE
    } state_t;

    localparam logic [TMO_W-1:0] WD_ONE  = TMO_W'(1);
    localparam logic [TMO_W-1:0] WD_MAX  = '1;
    localparam logic [TMO_W-1:0] WD_LAST = WD_MAX - WD_ONE;

    state_t            state_q, state_d;
    logic              gnt_tx_q, gnt_tx_d;
    logic              last_tx_q, last_tx_d;
    logic              dir_q, dir_d;
    logic [ADDR_W-1:0] sys_tmp_q, sys_tmp_d;
    logic [ADDR_W-1:0] sys_q, sys_d;
    logic [ADDR_W-1:0] blk_q, blk_d;
    logic [TMO_W-1:0]  wdog_q, wdog_d;
    logic              err_q, err_d;
    logic              tmo_q, tmo_d;

    logic              tx_pend, rx_pend, pick_tx;
    logic              ack_sel, wd_hit, abort;
    logic              set_err, set_tmo, clr_tmo;
    logic [ADDR_W-1:0] dat_sel;

    assign tx_pend = (bus.tx_free_bd != CNT_W'(BD_NUM));
    assign rx_pend = (bus.rx_free_bd != CNT_W'(BD_NUM));
`ifdef SD_BD_SCHED_TX_PRIO_EN
    assign pick_tx = tx_pend;
`else
    // Round-robin: on contention the queue not served last wins.
    assign pick_tx = tx_pend && (!rx_pend || !last_tx_q);
`endif
    assign ack_sel = gnt_tx_q ? bus.tx_ack : bus.rx_ack;
    assign dat_sel = gnt_tx_q ? bus.tx_dat : bus.rx_dat;
    // Hit on the cycle whose increment brings the watchdog to all-ones.
    assign wd_hit  = (wdog_q == WD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_tx_q  <= 1'b0;
            last_tx_q <= 1'b0;
            dir_q     <= 1'b0;
            sys_tmp_q <= '0;
            sys_q     <= '0;
            blk_q     <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_tx_q  <= gnt_tx_d;
            last_tx_q <= last_tx_d;
            dir_q     <= dir_d;
            sys_tmp_q <= sys_tmp_d;
            sys_q     <= sys_d;
            blk_q     <= blk_d;
            wdog_q    <= wdog_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_tx_d  = gnt_tx_q;
        last_tx_d = last_tx_q;
        dir_d     = dir_q;
        sys_tmp_d = sys_tmp_q;
        sys_d     = sys_q;
        blk_d     = blk_q;
        wdog_d    = '0;
        set_err   = 1'b0;
        set_tmo   = 1'b0;
        clr_tmo   = 1'b0;
        abort     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.enable && (tx_pend || rx_pend)) begin
                    gnt_tx_d = pick_tx;
                    state_d  = S_RD0;
                end
            end
            S_RD0: state_d = S_W0;
            S_W0: begin
                if (ack_sel) begin
                    sys_tmp_d = dat_sel;
                    state_d   = S_RD1;
                end else if (wd_hit) begin
                    set_err = 1'b1;
                    set_tmo = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdog_d = wdog_q + WD_ONE;
                end
            end
            S_RD1: state_d = S_W1;
            S_W1: begin
                // Outputs change only here so they stay stable for the whole transfer.
                if (ack_sel) begin
                    sys_d   = sys_tmp_q;
                    blk_d   = dat_sel;
                    dir_d   = gnt_tx_q;
                    state_d = S_START;
                end else if (wd_hit) begin
                    set_err = 1'b1;
                    set_tmo = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdog_d = wdog_q + WD_ONE;
                end
            end
            S_START: state_d = S_XFER;
            S_XFER: begin
                if (bus.xfer_err) begin
                    set_err = 1'b1;
                    clr_tmo = 1'b1;
                    state_d = S_CMP1;
                end else if (bus.xfer_done) begin
                    state_d = S_CMP1;
                end else if (wd_hit) begin
                    abort   = 1'b1;
                    set_err = 1'b1;
                    set_tmo = 1'b1;
                    state_d = S_CMP1;
                end else begin
                    wdog_d = wdog_q + WD_ONE;
                end
            end
            S_CMP1: begin
                last_tx_d = gnt_tx_q;
                state_d   = S_CMP2;
            end
            S_CMP2:   state_d = S_SETTLE;
            S_SETTLE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // A same-cycle set wins over err_clr.
        err_d = err_q;
        tmo_d = tmo_q;
        if (bus.err_clr) begin
            err_d = 1'b0;
            tmo_d = 1'b0;
        end
        if (set_err) err_d = 1'b1;
        if (set_tmo) tmo_d = 1'b1;
        else if (clr_tmo) tmo_d = 1'b0;
    end

    assign bus.tx_re         = ((state_q == S_RD0) || (state_q == S_RD1)) && gnt_tx_q;
    assign bus.rx_re         = ((state_q == S_RD0) || (state_q == S_RD1)) && !gnt_tx_q;
    assign bus.tx_a_cmp      = ((state_q == S_CMP1) || (state_q == S_CMP2)) && gnt_tx_q;
    assign bus.rx_a_cmp      = ((state_q == S_CMP1) || (state_q == S_CMP2)) && !gnt_tx_q;
    assign bus.xfer_start    = (state_q == S_START);
    assign bus.xfer_dir      = dir_q;
    assign bus.xfer_sys_addr = sys_q;
    assign bus.xfer_blk_addr = blk_q;
    assign bus.xfer_abort    = abort;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.err           = err_q;
    assign bus.err_tmo       = tmo_q;
endmodule

// File: tb/tb_sd_bd_sched.sv
// Self-checking bench for sd_bd_sched: queue/engine responders plus a descriptor-order reference model.
module tb_sd_bd_sched;
    localparam int BD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sd_bd_sched_if #(.ADDR_W(32), .CNT_W(3)) bus ();

    sd_bd_sched #(.ADDR_W(32), .CNT_W(3), .BD_NUM(BD), .TMO_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] sys; logic [31:0] blk; } desc_t;
    typedef struct { logic dir; logic [31:0] sys; logic [31:0] blk; } xfer_t;

    desc_t q_tx[$];
    desc_t q_rx[$];
    xfer_t exp_q[$];
    int    re_cycs[$];
    logic  svc[$];

    int   checks = 0, errors = 0, cyc = 0;
    int   ack_cnt = 0, ack_extra = 0, done_cnt = 0, done_dly = 0;
    int   eng_mode = 0, cur_mode = 0, cmp_len_tx = 0, cmp_len_rx = 0;
    int   retired = 0, start_cnt = 0, abort_cnt = 0, exp_aborts = 0;
    int   last_start_cyc = 0, last_abort_cyc = 0, cmp_rise_cyc = 0, rx_re_cnt = 0;
    bit   ack_en = 1'b1, ack_tx = 1'b0, widx_tx = 1'b0, widx_rx = 1'b0;
    bit   prev_re = 1'b0, rand_mode = 1'b0, cur_exp_dir = 1'b0;
    bit   m_last_tx = 1'b0, m_err = 1'b0, m_tmo = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic update_free();
        bus.tx_free_bd = 3'(BD - q_tx.size());
        bus.rx_free_bd = 3'(BD - q_rx.size());
    endtask

    // Reference order: walk the queued descriptors applying the arbitration rule.
    task automatic plan();
        int  it = 0, ir = 0;
        bit  pick;
        bit  last = m_last_tx;
        while (it < q_tx.size() || ir < q_rx.size()) begin
`ifdef SD_BD_SCHED_TX_PRIO_EN
            pick = (it < q_tx.size());
`else
            pick = (it < q_tx.size()) && (!(ir < q_rx.size()) || !last);
`endif
            if (pick) begin
                exp_q.push_back('{dir: 1'b1, sys: q_tx[it].sys, blk: q_tx[it].blk});
                it++;
            end else begin
                exp_q.push_back('{dir: 1'b0, sys: q_rx[ir].sys, blk: q_rx[ir].blk});
                ir++;
            end
            last = pick;
        end
        m_last_tx = last;
    endtask

    task automatic drive_ack();
        if (ack_tx) begin
            if (q_tx.size() == 0) bus.tx_dat = 32'hDEAD_BEEF;
            else bus.tx_dat = widx_tx ? q_tx[0].blk : q_tx[0].sys;
            widx_tx = !widx_tx;
            bus.tx_ack = 1'b1;
        end else begin
            if (q_rx.size() == 0) bus.rx_dat = 32'hDEAD_BEEF;
            else bus.rx_dat = widx_rx ? q_rx[0].blk : q_rx[0].sys;
            widx_rx = !widx_rx;
            bus.rx_ack = 1'b1;
        end
    endtask

    task automatic retire(input bit is_tx);
        chk("cmp_owner", 32'(is_tx), 32'(cur_exp_dir));
        chk("cmp_err", 32'(bus.err), 32'(m_err));
        chk("cmp_tmo", 32'(bus.err_tmo), 32'(m_tmo));
        if (is_tx && q_tx.size() > 0) q_tx.delete(0);
        if (!is_tx && q_rx.size() > 0) q_rx.delete(0);
        retired++;
        if (cur_mode == 3) exp_aborts++;
    endtask

    // One clock: sample DUT #1 after the edge, run monitors and responders, drive next inputs.
    task automatic tick();
        xfer_t x;
        @(posedge clk);
        #1;
        cyc++;
        bus.tx_ack    = 1'b0;
        bus.rx_ack    = 1'b0;
        bus.xfer_done = 1'b0;
        bus.xfer_err  = 1'b0;

        if (bus.tx_re || bus.rx_re) begin
            chk("re_excl", 32'(bus.tx_re & bus.rx_re), 0);
            chk("re_gap", 32'(prev_re), 0);
            re_cycs.push_back(cyc);
            if (bus.rx_re) rx_re_cnt++;
        end
        prev_re = bus.tx_re | bus.rx_re;
        if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) drive_ack();
        end
        if ((bus.tx_re || bus.rx_re) && ack_en) begin
            ack_tx  = bus.tx_re;
            ack_cnt = 1 + int'($urandom_range(ack_extra, 0));
        end

        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
                bus.xfer_done = (cur_mode != 1);
                bus.xfer_err  = (cur_mode != 0);
            end
        end
        if (bus.xfer_abort) begin
            abort_cnt++;
            last_abort_cyc = cyc;
        end
        if (bus.xfer_start) begin
            start_cnt++;
            last_start_cyc = cyc;
            svc.push_back(bus.xfer_dir);
            cur_mode = rand_mode ? int'($urandom_range(3, 0)) : eng_mode;
            if (exp_q.size() == 0) begin
                chk("start_unexpected", 1, 0);
            end else begin
                x = exp_q.pop_front();
                cur_exp_dir = x.dir;
                chk("start_dir", 32'(bus.xfer_dir), 32'(x.dir));
                chk("start_sys", bus.xfer_sys_addr, x.sys);
                chk("start_blk", bus.xfer_blk_addr, x.blk);
            end
            if (cur_mode != 0) m_err = 1'b1;
            if (cur_mode == 3) m_tmo = 1'b1;
            else if (cur_mode != 0) m_tmo = 1'b0;
            if (cur_mode != 3) done_cnt = (done_dly > 0) ? done_dly : 1 + int'($urandom_range(9, 0));
        end

        if (bus.tx_a_cmp || bus.rx_a_cmp) chk("cmp_excl", 32'(bus.tx_a_cmp & bus.rx_a_cmp), 0);
        if (bus.tx_a_cmp) begin
            if (cmp_len_tx == 0) cmp_rise_cyc = cyc;
            cmp_len_tx++;
        end else if (cmp_len_tx > 0) begin
            chk("tx_cmp_len", cmp_len_tx, 2);
            retire(1'b1);
            cmp_len_tx = 0;
        end
        if (bus.rx_a_cmp) begin
            if (cmp_len_rx == 0) cmp_rise_cyc = cyc;
            cmp_len_rx++;
        end else if (cmp_len_rx > 0) begin
            chk("rx_cmp_len", cmp_len_rx, 2);
            retire(1'b0);
            cmp_len_rx = 0;
        end
        if (!bus.busy) begin
            widx_tx = 1'b0;
            widx_rx = 1'b0;
        end
        update_free();
    endtask

    task automatic do_reset();
        bus.enable = 1'b0;
        rst        = 1'b1;
        ack_cnt    = 0;
        done_cnt   = 0;
        m_last_tx  = 1'b0;
        m_err      = 1'b0;
        m_tmo      = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_round(input string tag);
        int n      = exp_q.size();
        int r0     = retired;
        int budget = 40 * (n + 1);
        bus.enable = 1'b1;
        while (((retired - r0) < n) || bus.busy) begin
            if (budget == 0) break;
            budget--;
            tick();
        end
        bus.enable = 1'b0;
        chk({tag, "_retired"}, retired - r0, n);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_aborts"}, abort_cnt, exp_aborts);
    endtask

    task automatic load(input bit is_tx, input logic [31:0] sys, input logic [31:0] blk);
        if (is_tx) q_tx.push_back('{sys: sys, blk: blk});
        else q_rx.push_back('{sys: sys, blk: blk});
        update_free();
    endtask

    initial begin
        int t0, r0, s0, budget;
        logic [3:0] pat;
        bus.enable = 1'b0;
        bus.tx_ack = 1'b0;
        bus.rx_ack = 1'b0;
        bus.tx_dat = '0;
        bus.rx_dat = '0;
        bus.xfer_done = 1'b0;
        bus.xfer_err  = 1'b0;
        bus.err_clr   = 1'b0;
        update_free();
        tick();

        // Reset state
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_strobes", 32'({bus.tx_re, bus.rx_re, bus.tx_a_cmp, bus.rx_a_cmp,
                                bus.xfer_start, bus.xfer_abort}), 0);
        chk("rst_dir", 32'(bus.xfer_dir), 0);
        chk("rst_sys", bus.xfer_sys_addr, 0);
        chk("rst_blk", bus.xfer_blk_addr, 0);
        chk("rst_err", 32'({bus.err, bus.err_tmo}), 0);
        rst = 1'b0;
        tick();

        // Single TX descriptor, done 10 cycles after start: exact timing
        load(1'b1, 32'h1000, 32'h20);
        plan();
        eng_mode = 0; rand_mode = 1'b0; done_dly = 10; ack_extra = 0;
        re_cycs.delete();
        rx_re_cnt = 0;
        r0 = retired;
        t0 = cyc;
        bus.enable = 1'b1;
        budget = 40;
        do begin tick(); budget--; end while ((bus.busy || retired == r0) && budget > 0);
        bus.enable = 1'b0;
        chk("t1_re0_cyc", (re_cycs.size() > 0) ? re_cycs[0] : -1, t0 + 1);
        chk("t1_re1_cyc", (re_cycs.size() > 1) ? re_cycs[1] : -1, t0 + 3);
        chk("t1_start_cyc", last_start_cyc, t0 + 5);
        chk("t1_cmp_rise", cmp_rise_cyc, t0 + 16);
        chk("t1_idle_cyc", cyc, t0 + 19);
        chk("t1_retired", retired - r0, 1);
        chk("t1_rx_idle", rx_re_cnt, 0);

        // Both queues pending from reset: service order
        do_reset();
        for (int i = 0; i < 2; i++) begin
            load(1'b1, $urandom(), $urandom());
            load(1'b0, $urandom(), $urandom());
        end
        plan();
        done_dly = 0; ack_extra = 2;
        svc.delete();
        run_round("order");
`ifdef SD_BD_SCHED_TX_PRIO_EN
        pat = 4'b1100;
`else
        pat = 4'b1010;
`endif
        chk("order_len", svc.size(), 4);
        for (int i = 0; i < 4; i++) chk("order_dir", (svc.size() > i) ? 32'(svc[i]) : 32'hF, 32'(pat[3-i]));

        // err and done together: err wins, descriptor still retired, then clear
        load(1'b0, 32'hA000, 32'h44);
        plan();
        eng_mode = 2; done_dly = 3;
        run_round("errdone");
        chk("errdone_err", 32'(bus.err), 1);
        chk("errdone_tmo", 32'(bus.err_tmo), 0);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        m_err = 1'b0; m_tmo = 1'b0;
        chk("errclr_err", 32'(bus.err), 0);

        // Watchdog timeout in XFER
        load(1'b1, 32'hB000, 32'h55);
        plan();
        eng_mode = 3;
        run_round("tmo");
        chk("tmo_abort_cyc", last_abort_cyc, last_start_cyc + 15);
        chk("tmo_flags", 32'({bus.err, bus.err_tmo}), 32'b11);

        // Reset during XFER
        do_reset();
        load(1'b1, 32'hC000, 32'h66);
        plan();
        eng_mode = 3;
        s0 = start_cnt; r0 = retired;
        bus.enable = 1'b1;
        budget = 20;
        do begin tick(); budget--; end while (start_cnt == s0 && budget > 0);
        chk("rstx_started", start_cnt - s0, 1);
        tick();
        tick();
        chk("rstx_busy_pre", 32'(bus.busy), 1);
        rst = 1'b1;
        bus.enable = 1'b0;
        tick();
        chk("rstx_busy", 32'(bus.busy), 0);
        chk("rstx_strobes", 32'({bus.tx_re, bus.rx_re, bus.tx_a_cmp, bus.rx_a_cmp,
                                 bus.xfer_start, bus.xfer_abort}), 0);
        chk("rstx_dir", 32'(bus.xfer_dir), 0);
        chk("rstx_addr", bus.xfer_sys_addr | bus.xfer_blk_addr, 0);
        chk("rstx_err", 32'({bus.err, bus.err_tmo}), 0);
        tick();
        tick();
        chk("rstx_no_cmp", retired - r0, 0);
        q_tx.delete();
        update_free();
        do_reset();

        // enable low holds off fetches; dropping it mid-transfer finishes only the current one
        load(1'b1, 32'hD000, 32'h77);
        load(1'b0, 32'hE000, 32'h88);
        re_cycs.delete();
        repeat (20) tick();
        chk("en0_no_re", re_cycs.size(), 0);
        plan();
        eng_mode = 0; done_dly = 5;
        s0 = start_cnt; r0 = retired;
        bus.enable = 1'b1;
        budget = 20;
        do begin tick(); budget--; end while (start_cnt == s0 && budget > 0);
        tick();
        bus.enable = 1'b0;
        budget = 40;
        do begin tick(); budget--; end while ((bus.busy || retired == r0) && budget > 0);
        repeat (10) tick();
        chk("endrop_re", re_cycs.size(), 2);
        chk("endrop_retired", retired - r0, 1);
        chk("endrop_busy", 32'(bus.busy), 0);
        exp_q.delete();
        q_rx.delete();
        update_free();

        // Descriptor-word timeout in W0: error flags, no retire
        do_reset();
        load(1'b0, 32'hF000, 32'h99);
        ack_en = 1'b0;
        re_cycs.delete();
        s0 = start_cnt; r0 = retired;
        bus.enable = 1'b1;
        budget = 20;
        do begin tick(); budget--; end while (re_cycs.size() == 0 && budget > 0);
        bus.enable = 1'b0;
        budget = 40;
        do begin tick(); budget--; end while (bus.busy && budget > 0);
        chk("w0tmo_idle_cyc", cyc, (re_cycs.size() > 0) ? re_cycs[0] + 16 : -1);
        chk("w0tmo_flags", 32'({bus.err, bus.err_tmo}), 32'b11);
        chk("w0tmo_no_cmp", retired - r0, 0);
        chk("w0tmo_no_start", start_cnt - s0, 0);
        ack_en = 1'b1;
        q_rx.delete();
        update_free();

        // Randomized rounds against the reference order, last_tx carried across rounds
        do_reset();
        rand_mode = 1'b1; done_dly = 0;
        for (int r = 0; r < 8; r++) begin
            bus.err_clr = 1'b1;
            tick();
            bus.err_clr = 1'b0;
            m_err = 1'b0; m_tmo = 1'b0;
            for (int i = 0; i < int'($urandom_range(BD, 0)); i++) load(1'b1, $urandom(), $urandom());
            for (int i = 0; i < int'($urandom_range(BD, 0)); i++) load(1'b0, $urandom(), $urandom());
            ack_extra = int'($urandom_range(2, 0));
            plan();
            run_round("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
